// File: rtl/calc_pkg.sv
// Shared definitions for the calculator key-entry front end, ALU and display driver.
package calc_pkg;

   localparam int PHASE_W = 3;

   typedef enum logic [PHASE_W-1:0] {
      ST_ENTER_A  = 3'd0,
      ST_SELECT_OP = 3'd1,
      ST_ENTER_B  = 3'd2,
      ST_ISSUE    = 3'd3,
      ST_SHOW     = 3'd4
   } state_t;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_AND = 2'd2;
   localparam logic [1:0] OP_OR  = 2'd3;

endpackage

// File: rtl/calc_digit_edit.sv
// Increments or decrements one hex nibble of a value, wrapping within the nibble.
module calc_digit_edit #(
   parameter int W = 16,
   localparam int DIGITS = W / 4,
   localparam int CW = $clog2(DIGITS)
) (
   input  logic [W-1:0]  value,
   input  logic [CW-1:0] cursor,
   input  logic          inc,
   input  logic          dec,
   output logic [W-1:0]  result
);

   logic [3:0] nib;

   always_comb begin
      result = value;
      nib    = value[{cursor, 2'b00} +: 4];
      // Nibble arithmetic is 4 bits wide, so carries never reach the neighbours
      if (inc)
         result[{cursor, 2'b00} +: 4] = nib + 4'd1;
      else if (dec)
         result[{cursor, 2'b00} +: 4] = nib - 4'd1;
   end

endmodule

// File: rtl/calc_key_entry.sv
// Turns debounced button presses into two hex operands and an opcode, then offers them to the ALU.
module calc_key_entry
   import calc_pkg::*;
#(
   parameter int W = 16,
   localparam int DIGITS = W / 4,
   localparam int CW = $clog2(DIGITS)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               btn_up,
   input  logic               btn_down,
   input  logic               btn_left,
   input  logic               btn_right,
   input  logic               btn_center,
   input  logic               calc_ready,
   output logic [W-1:0]       operand_a,
   output logic [W-1:0]       operand_b,
   output logic [1:0]         opcode,
   output logic [CW-1:0]      cursor,
   output logic [PHASE_W-1:0] phase,
   output logic               calc_valid
);

   state_t        state, next_state;
   logic [W-1:0]  operand_a_n, operand_b_n;
   logic [1:0]    opcode_n;
   logic [CW-1:0] cursor_n;
   logic          calc_valid_n;
   logic [W-1:0]  edit_value, edit_result;
   logic          ev_center, ev_up, ev_down, ev_left, ev_right;

   // One event per cycle: higher-priority presses mask the rest
   assign ev_center = btn_center;
   assign ev_up     = btn_up    & ~btn_center;
   assign ev_down   = btn_down  & ~btn_center & ~btn_up;
   assign ev_left   = btn_left  & ~btn_center & ~btn_up & ~btn_down;
   assign ev_right  = btn_right & ~btn_center & ~btn_up & ~btn_down & ~btn_left;

   assign edit_value = (state == ST_ENTER_B) ? operand_b : operand_a;

   calc_digit_edit #(.W(W)) u_digit_edit (
      .value  (edit_value),
      .cursor (cursor),
      .inc    (ev_up),
      .dec    (ev_down),
      .result (edit_result)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ST_ENTER_A;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_ENTER_A:   if (ev_center) next_state = ST_SELECT_OP;
         ST_SELECT_OP: if (ev_center) next_state = ST_ENTER_B;
         ST_ENTER_B:   if (ev_center) next_state = ST_ISSUE;
         ST_ISSUE:     if (calc_valid && calc_ready) next_state = ST_SHOW;
         ST_SHOW:      if (ev_center) next_state = ST_ENTER_A;
         default:      next_state = ST_ENTER_A;
      endcase
   end

   always_comb begin
      operand_a_n = operand_a;
      operand_b_n = operand_b;
      opcode_n    = opcode;
      cursor_n    = cursor;
      case (state)
         ST_ENTER_A, ST_ENTER_B: begin
            if (ev_up || ev_down) begin
               if (state == ST_ENTER_A)
                  operand_a_n = edit_result;
               else
                  operand_b_n = edit_result;
            end
            if (ev_left)
               cursor_n = (cursor == CW'(DIGITS - 1)) ? '0 : cursor + CW'(1);
            else if (ev_right)
               cursor_n = (cursor == '0) ? CW'(DIGITS - 1) : cursor - CW'(1);
         end
         ST_SELECT_OP: begin
            if (ev_up)
               opcode_n = opcode + 2'd1;
            else if (ev_down)
               opcode_n = opcode - 2'd1;
         end
         ST_SHOW: begin
            if (ev_center) begin
               operand_a_n = '0;
               operand_b_n = '0;
               opcode_n    = OP_ADD;
            end
         end
         default: ;
      endcase
      if (next_state != state)
         cursor_n = '0;
      // Valid is asserted on entry to ISSUE and held until the transfer edge
      calc_valid_n = (next_state == ST_ISSUE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         operand_a  <= '0;
         operand_b  <= '0;
         opcode     <= OP_ADD;
         cursor     <= '0;
         calc_valid <= 1'b0;
      end else begin
         operand_a  <= operand_a_n;
         operand_b  <= operand_b_n;
         opcode     <= opcode_n;
         cursor     <= cursor_n;
         calc_valid <= calc_valid_n;
      end
   end

   assign phase = state;

endmodule

// File: tb/tb_calc_key_entry.sv
// Table-driven scoreboard bench for calc_key_entry.
module tb_calc_key_entry;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic [1:0]  op;
      logic [1:0]  cur;
      logic [2:0]  ph;
      logic        vld;
   } exp_t;

   typedef struct {
      logic [4:0] btn;
      logic       rdy;
      exp_t       e;
   } vec_t;

   localparam logic [4:0] C = 5'b10000;
   localparam logic [4:0] U = 5'b01000;
   localparam logic [4:0] D = 5'b00100;
   localparam logic [4:0] L = 5'b00010;
   localparam logic [4:0] R = 5'b00001;
   localparam logic [4:0] N = 5'b00000;

   logic        clk = 1'b0;
   logic        rst;
   logic        btn_up, btn_down, btn_left, btn_right, btn_center;
   logic        calc_ready;
   logic [15:0] operand_a, operand_b;
   logic [1:0]  opcode;
   logic [1:0]  cursor;
   logic [2:0]  phase;
   logic        calc_valid;

   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];
   vec_t vecs[64];
   int   nv = 0;

   calc_key_entry #(.W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_up     (btn_up),
      .btn_down   (btn_down),
      .btn_left   (btn_left),
      .btn_right  (btn_right),
      .btn_center (btn_center),
      .calc_ready (calc_ready),
      .operand_a  (operand_a),
      .operand_b  (operand_b),
      .opcode     (opcode),
      .cursor     (cursor),
      .phase      (phase),
      .calc_valid (calc_valid)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(logic [15:0] a, logic [15:0] b, logic [1:0] op,
                               logic [1:0] cur, logic [2:0] ph, logic vld);
      exp_t e;
      e.a = a; e.b = b; e.op = op; e.cur = cur; e.ph = ph; e.vld = vld;
      return e;
   endfunction

   function automatic void add(logic [4:0] btn, logic rdy, exp_t e);
      vecs[nv].btn = btn;
      vecs[nv].rdy = rdy;
      vecs[nv].e   = e;
      nv++;
   endfunction

   task automatic check(input string nm, input exp_t e);
      exp_t act;
      act = {operand_a, operand_b, opcode, cursor, phase, calc_valid};
      total++;
      if (act !== e) begin
         bad++;
         $display("FAIL %s: got a=%h b=%h op=%0d cur=%0d ph=%0d vld=%0b want a=%h b=%h op=%0d cur=%0d ph=%0d vld=%0b",
                  nm, act.a, act.b, act.op, act.cur, act.ph, act.vld,
                  e.a, e.b, e.op, e.cur, e.ph, e.vld);
      end
   endtask

   task automatic pop_check(input string nm);
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s: got output with empty scoreboard, want queued expectation", nm);
      end else begin
         check(nm, exp_q.pop_front());
      end
   endtask

   task automatic step(input logic [4:0] btn, input logic rdy, input exp_t e, input string nm);
      @(negedge clk);
      {btn_center, btn_up, btn_down, btn_left, btn_right} = btn;
      calc_ready = rdy;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      {btn_center, btn_up, btn_down, btn_left, btn_right} = N;
      pop_check(nm);
   endtask

   initial begin
      rst = 1'b1;
      {btn_center, btn_up, btn_down, btn_left, btn_right} = N;
      calc_ready = 1'b0;

      // Operand A editing, nibble wrap, cursor wrap, priority
      add(U, 0, mk(16'h0001, 16'h0000, 2'd0, 2'd0, 3'd0, 0));
      add(U, 0, mk(16'h0002, 16'h0000, 2'd0, 2'd0, 3'd0, 0));
      add(U, 0, mk(16'h0003, 16'h0000, 2'd0, 2'd0, 3'd0, 0));
      add(L, 0, mk(16'h0003, 16'h0000, 2'd0, 2'd1, 3'd0, 0));
      add(D, 0, mk(16'h00F3, 16'h0000, 2'd0, 2'd1, 3'd0, 0));
      add(D, 0, mk(16'h00E3, 16'h0000, 2'd0, 2'd1, 3'd0, 0));
      add(R, 0, mk(16'h00E3, 16'h0000, 2'd0, 2'd0, 3'd0, 0));
      add(D, 0, mk(16'h00E2, 16'h0000, 2'd0, 2'd0, 3'd0, 0));
      add(D, 0, mk(16'h00E1, 16'h0000, 2'd0, 2'd0, 3'd0, 0));
      add(D, 0, mk(16'h00E0, 16'h0000, 2'd0, 2'd0, 3'd0, 0));
      add(D, 0, mk(16'h00EF, 16'h0000, 2'd0, 2'd0, 3'd0, 0));
      add(U, 0, mk(16'h00E0, 16'h0000, 2'd0, 2'd0, 3'd0, 0));
      add(R, 0, mk(16'h00E0, 16'h0000, 2'd0, 2'd3, 3'd0, 0));
      add(U, 0, mk(16'h10E0, 16'h0000, 2'd0, 2'd3, 3'd0, 0));
      add(L, 0, mk(16'h10E0, 16'h0000, 2'd0, 2'd0, 3'd0, 0));
      add(U | D, 0, mk(16'h10E1, 16'h0000, 2'd0, 2'd0, 3'd0, 0));
      add(L | R, 0, mk(16'h10E1, 16'h0000, 2'd0, 2'd1, 3'd0, 0));
      // Opcode selection
      add(C, 0, mk(16'h10E1, 16'h0000, 2'd0, 2'd0, 3'd1, 0));
      add(L, 0, mk(16'h10E1, 16'h0000, 2'd0, 2'd0, 3'd1, 0));
      add(U, 0, mk(16'h10E1, 16'h0000, 2'd1, 2'd0, 3'd1, 0));
      add(U, 0, mk(16'h10E1, 16'h0000, 2'd2, 2'd0, 3'd1, 0));
      add(U, 0, mk(16'h10E1, 16'h0000, 2'd3, 2'd0, 3'd1, 0));
      add(U, 0, mk(16'h10E1, 16'h0000, 2'd0, 2'd0, 3'd1, 0));
      add(U, 0, mk(16'h10E1, 16'h0000, 2'd1, 2'd0, 3'd1, 0));
      add(D, 0, mk(16'h10E1, 16'h0000, 2'd0, 2'd0, 3'd1, 0));
      add(U, 0, mk(16'h10E1, 16'h0000, 2'd1, 2'd0, 3'd1, 0));
      add(U | C, 0, mk(16'h10E1, 16'h0000, 2'd1, 2'd0, 3'd2, 0));
      // Operand B
      add(U, 0, mk(16'h10E1, 16'h0001, 2'd1, 2'd0, 3'd2, 0));
      add(U, 0, mk(16'h10E1, 16'h0002, 2'd1, 2'd0, 3'd2, 0));
      add(L, 0, mk(16'h10E1, 16'h0002, 2'd1, 2'd1, 3'd2, 0));
      add(U, 0, mk(16'h10E1, 16'h0012, 2'd1, 2'd1, 3'd2, 0));
      // Issue with back-pressure; buttons ignored
      add(C, 0, mk(16'h10E1, 16'h0012, 2'd1, 2'd0, 3'd3, 1));
      add(U, 0, mk(16'h10E1, 16'h0012, 2'd1, 2'd0, 3'd3, 1));
      add(D, 0, mk(16'h10E1, 16'h0012, 2'd1, 2'd0, 3'd3, 1));
      add(C, 0, mk(16'h10E1, 16'h0012, 2'd1, 2'd0, 3'd3, 1));
      add(L, 0, mk(16'h10E1, 16'h0012, 2'd1, 2'd0, 3'd3, 1));
      add(N, 1, mk(16'h10E1, 16'h0012, 2'd1, 2'd0, 3'd4, 0));
      // Show, then clear
      add(U, 0, mk(16'h10E1, 16'h0012, 2'd1, 2'd0, 3'd4, 0));
      add(R, 1, mk(16'h10E1, 16'h0012, 2'd1, 2'd0, 3'd4, 0));
      add(C, 0, mk(16'h0000, 16'h0000, 2'd0, 2'd0, 3'd0, 0));

      repeat (2) @(negedge clk);
      check("reset_values", mk(16'h0000, 16'h0000, 2'd0, 2'd0, 3'd0, 0));
      rst = 1'b0;

      for (int i = 0; i < nv; i++)
         step(vecs[i].btn, vecs[i].rdy, vecs[i].e, $sformatf("vec%0d", i));

      // Ready already high on entry: valid lasts exactly one cycle
      step(C, 1, mk(16'h0000, 16'h0000, 2'd0, 2'd0, 3'd1, 0), "fast_sel");
      step(C, 1, mk(16'h0000, 16'h0000, 2'd0, 2'd0, 3'd2, 0), "fast_b");
      step(C, 1, mk(16'h0000, 16'h0000, 2'd0, 2'd0, 3'd3, 1), "fast_issue");
      step(N, 1, mk(16'h0000, 16'h0000, 2'd0, 2'd0, 3'd4, 0), "fast_show");
      step(C, 0, mk(16'h0000, 16'h0000, 2'd0, 2'd0, 3'd0, 0), "fast_clear");

      // Reset while offering an operation
      step(U, 0, mk(16'h0001, 16'h0000, 2'd0, 2'd0, 3'd0, 0), "rst_seq_a");
      step(C, 0, mk(16'h0001, 16'h0000, 2'd0, 2'd0, 3'd1, 0), "rst_seq_sel");
      step(U, 0, mk(16'h0001, 16'h0000, 2'd1, 2'd0, 3'd1, 0), "rst_seq_op");
      step(C, 0, mk(16'h0001, 16'h0000, 2'd1, 2'd0, 3'd2, 0), "rst_seq_b");
      step(D, 0, mk(16'h0001, 16'h000F, 2'd1, 2'd0, 3'd2, 0), "rst_seq_bv");
      step(C, 0, mk(16'h0001, 16'h000F, 2'd1, 2'd0, 3'd3, 1), "rst_seq_issue");
      @(negedge clk);
      rst = 1'b1;
      calc_ready = 1'b1;
      #1;
      check("rst_async", mk(16'h0000, 16'h0000, 2'd0, 2'd0, 3'd0, 0));
      @(posedge clk);
      #1;
      check("rst_held", mk(16'h0000, 16'h0000, 2'd0, 2'd0, 3'd0, 0));
      @(negedge clk);
      rst = 1'b0;
      calc_ready = 1'b0;
      step(N, 1, mk(16'h0000, 16'h0000, 2'd0, 2'd0, 3'd0, 0), "after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
